edge_detect_bank: RTL and testbench



---
 rtl/edge_detect_bank.sv | 62 ++++++
 tb/tb_edge_detect_bank.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_bank.sv
// edge_detect_bank: per-channel synchroniser, debounce filter and mode-selectable edge detector
// with one-cycle pulses, sticky event flags and a global any_event summary.
module edge_detect_bank #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    input  logic [1:0]       edge_mode,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] sig_stable,
    output logic [WIDTH-1:0] sig_pulse,
    output logic [WIDTH-1:0] sig_sticky,
    output logic             any_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d, pulse_q, pulse_d, sticky_q, sticky_d;
    logic [WIDTH-1:0] sync_out, toggle;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Counter restarts on any return to match, so short glitches never get accepted.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = (sync_out[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
            cnt_d[i]  = (sync_out[i] == stable_q[i] || toggle[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        stable_d = stable_q ^ toggle;
        pulse_d  = toggle & ((~stable_q & {WIDTH{edge_mode[0]}}) | (stable_q & {WIDTH{edge_mode[1]}}));
        sticky_d = pulse_d | (sticky_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
        end else begin
            sync_q[0] <= sig;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    assign sig_stable = stable_q;
    assign sig_pulse  = pulse_q;
    assign sig_sticky = sticky_q;
    assign any_event  = |sticky_q;
endmodule

// File: tb/tb_edge_detect_bank.sv
// tb_edge_detect_bank: directed scenarios plus randomized traffic, checked against a
// sample-window reference model of synchroniser, debounce and edge qualification.
module tb_edge_detect_bank;
    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sig = '0;
    logic [W-1:0] clr = '0;
    logic [1:0]   edge_mode = 2'b01;
    logic [W-1:0] sig_stable, sig_pulse, sig_sticky;
    logic         any_event;
    int           checks = 0;
    int           errors = 0;

    edge_detect_bank #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig), .edge_mode(edge_mode), .clr(clr),
        .sig_stable(sig_stable), .sig_pulse(sig_pulse), .sig_sticky(sig_sticky),
        .any_event(any_event)
    );

    always #5 clk = ~clk;

    // Reference model: hist[e] is the raw input sampled on the e-th edge since reset.
    // A channel accepts a new level once the last D synchronised samples all differ from
    // the accepted level and at least D edges have passed since its previous acceptance.
    logic [W-1:0] hist [8192];
    int           n;
    int           last_tog [W];
    logic [W-1:0] m_stable, m_pulse, m_sticky;

    function automatic logic [W-1:0] hs(int e);
        return (e < 0) ? '0 : hist[e];
    endfunction

    function automatic logic [W-1:0] tog_f();
        logic [W-1:0] t;
        logic [W-1:0] h;
        t = '0;
        for (int i = 0; i < W; i++) begin
            t[i] = (n - last_tog[i]) >= D;
            for (int k = 0; k < D; k++) begin
                h = hs(n - S - k);
                if (h[i] == m_stable[i]) t[i] = 1'b0;
            end
        end
        return t;
    endfunction

    function automatic logic [W-1:0] qual(logic [W-1:0] t);
        case (edge_mode)
            2'b01:   return t & ~m_stable;
            2'b10:   return t & m_stable;
            2'b11:   return t;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= 0;
            m_stable <= '0;
            m_pulse  <= '0;
            m_sticky <= '0;
            for (int i = 0; i < W; i++) last_tog[i] <= -1000;
        end else begin
            if (n < 8192) hist[n] <= sig;
            n        <= n + 1;
            m_stable <= m_stable ^ tog_f();
            m_pulse  <= qual(tog_f());
            m_sticky <= qual(tog_f()) | (m_sticky & ~clr);
            for (int i = 0; i < W; i++) if (|(tog_f() & (W'(1) << i))) last_tog[i] <= n;
        end
    end

    logic [3*W:0] dut_vec, mdl_vec;
    assign dut_vec = {sig_stable, sig_pulse, sig_sticky, any_event};
    assign mdl_vec = {m_stable, m_pulse, m_sticky, |m_sticky};

    task automatic test_reset();
        rst_n = 1'b0;
        sig = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", dut_vec);
        end
        sig = '0;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== '0 || mdl_vec !== '0) begin
                errors++;
                $display("FAIL reset_release j=%0d got=%h exp=0", j, dut_vec);
            end
        end
    endtask

    task automatic test_rise_latency();
        edge_mode = 2'b01;
        sig[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (sig_stable !== (j >= 5 ? 8'h01 : 8'h00) || sig_pulse !== (j == 5 ? 8'h01 : 8'h00) ||
                sig_sticky !== (j >= 5 ? 8'h01 : 8'h00) || any_event !== (j >= 5)) begin
                errors++;
                $display("FAIL rise_latency j=%0d stable=%h pulse=%h sticky=%h any=%b", j,
                         sig_stable, sig_pulse, sig_sticky, any_event);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL rise_model j=%0d got=%h exp=%h", j, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_glitch();
        int np, hi;
        for (int len = 3; len <= 4; len++) begin
            np = 0;
            hi = 0;
            sig[3] = 1'b1;
            for (int j = 0; j < len + 14; j++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++;
                    $display("FAIL glitch_model len=%0d j=%0d got=%h exp=%h", len, j, dut_vec, mdl_vec);
                end
                np += int'(sig_pulse[3]);
                hi += int'(sig_stable[3]);
                if (j == len - 1) sig[3] = 1'b0;
            end
            checks++;
            if (np != len - 3 || hi != (len == 4 ? 4 : 0) || sig_sticky[3] !== (len == 4)) begin
                errors++;
                $display("FAIL glitch len=%0d pulses=%0d high_cycles=%0d sticky=%b exp pulses=%0d",
                         len, np, hi, sig_sticky[3], len - 3);
            end
        end
    endtask

    task automatic test_fall_both();
        int np, pj;
        for (int m = 2; m <= 3; m++) begin
            edge_mode = 2'(m);
            np = 0;
            pj = -1;
            sig[5] = 1'b1;
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++;
                    $display("FAIL fall_model mode=%0d j=%0d got=%h exp=%h", m, j, dut_vec, mdl_vec);
                end
                if (sig_pulse[5]) begin
                    np++;
                    pj = j;
                end
                if (j == 9) sig[5] = 1'b0;
            end
            checks++;
            if (np != m - 1 || pj != 15) begin
                errors++;
                $display("FAIL fall_both mode=%0d pulses=%0d last_at=%0d exp pulses=%0d last_at=15",
                         m, np, pj, m - 1);
            end
        end
    endtask

    task automatic test_sticky_clr();
        clr = '1;
        @(negedge clk);
        clr = '0;
        checks++;
        if (sig_sticky !== '0 || any_event !== 1'b0) begin
            errors++;
            $display("FAIL clr_all sticky=%h any=%b exp 00/0", sig_sticky, any_event);
        end
        edge_mode = 2'b11;
        sig[2] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (sig_sticky !== 8'h04) begin
            errors++;
            $display("FAIL sticky_set got=%h exp=04", sig_sticky);
        end
        sig[2] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL sticky_model j=%0d got=%h exp=%h", j, dut_vec, mdl_vec);
            end
            if (j == 5) begin
                checks++;
                if (sig_pulse[2] !== 1'b1 || sig_sticky[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL set_wins pulse=%b sticky=%b exp 1/1", sig_pulse[2], sig_sticky[2]);
                end
            end
            if (j == 6) begin
                checks++;
                if (sig_sticky !== '0 || any_event !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_alone sticky=%h any=%b exp 00/0", sig_sticky, any_event);
                end
                clr[2] = 1'b0;
            end
            if (j == 4) clr[2] = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        edge_mode = 2'b01;
        sig[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL count_model j=%0d got=%h exp=%h", j, dut_vec, mdl_vec);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL async_reset_count got=%h exp=0", dut_vec);
        end
        sig = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sig[4] = 1'b1;
        for (int j = 0; j < 6; j++) @(negedge clk);
        checks++;
        if (sig_pulse !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset_pulse got=%h exp=10", sig_pulse);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL async_reset_pulse got=%h exp=0", dut_vec);
        end
        sig = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (sig_pulse !== (j == 5 ? 8'hFF : 8'h00) || sig_stable !== (j >= 5 ? 8'hFF : 8'h00) ||
                dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL held_high j=%0d stable=%h pulse=%h got=%h exp=%h", j, sig_stable,
                         sig_pulse, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_mode_none();
        int np;
        np = 0;
        clr = '1;
        @(negedge clk);
        clr = '0;
        edge_mode = 2'b00;
        for (int h = 0; h < 4; h++) begin
            sig[7] = ~sig[7];
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++;
                    $display("FAIL none_model h=%0d j=%0d got=%h exp=%h", h, j, dut_vec, mdl_vec);
                end
                np += int'(sig_pulse[7]);
            end
            checks++;
            if (sig_stable[7] !== sig[7]) begin
                errors++;
                $display("FAIL none_follow h=%0d got=%b exp=%b", h, sig_stable[7], sig[7]);
            end
        end
        checks++;
        if (np != 0 || sig_sticky !== '0) begin
            errors++;
            $display("FAIL none_quiet pulses=%0d sticky=%h exp 0/00", np, sig_sticky);
        end
    endtask

    task automatic test_fast_toggle();
        int nc;
        logic s0;
        nc = 0;
        edge_mode = 2'b11;
        s0 = sig_stable[6];
        for (int j = 0; j < 30; j++) begin
            sig[6] = ~sig[6];
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL toggle_model j=%0d got=%h exp=%h", j, dut_vec, mdl_vec);
            end
            if (sig_stable[6] !== s0 || sig_pulse[6] !== 1'b0) nc++;
        end
        checks++;
        if (nc != 0) begin
            errors++;
            $display("FAIL fast_toggle changed_cycles=%0d exp=0", nc);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 600; j++) begin
            if ($urandom_range(0, 3) == 0) sig = sig ^ (W'($urandom) & W'($urandom) & W'($urandom));
            clr = W'($urandom) & W'($urandom) & W'($urandom);
            if ($urandom_range(0, 39) == 0) edge_mode = 2'($urandom);
            if (j == 300) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL random j=%0d got=%h exp=%h", j, dut_vec, mdl_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_fall_both();
        test_sticky_clr();
        test_async_reset();
        test_mode_none();
        test_fast_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
